// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: default widths and source indices.
package rf_wb_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int RFIDX_WIDTH = 5;
  localparam int WB_NREQ     = 3;

  // Fixed requester slots on the writeback bus
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_MDU = 2;

  // Round-robin successor of a granted index, wrapping at n
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  // Walk the ring from ptr and stop at the first active request
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      automatic int idx = (int'(ptr) + k) % N;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = $clog2(N)'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with a one-stage write register and a
// busy-bit scoreboard used by decode for RAW/WAW stalls.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ        = WB_NREQ,
  parameter int XLEN        = rf_wb_arbiter_pkg::XLEN,
  parameter int RFIDX_WIDTH = rf_wb_arbiter_pkg::RFIDX_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             wb_valid,
  output logic [NREQ-1:0]             wb_ready,
  input  logic [NREQ*RFIDX_WIDTH-1:0] wb_addr,
  input  logic [NREQ*XLEN-1:0]        wb_data,
  output logic                        reg_write,
  output logic [RFIDX_WIDTH-1:0]      write_addr,
  output logic [XLEN-1:0]             write_data,
  input  logic                        iss_valid,
  input  logic [RFIDX_WIDTH-1:0]      iss_rd,
  output logic                        iss_ready,
  input  logic [RFIDX_WIDTH-1:0]      rs1_addr,
  input  logic [RFIDX_WIDTH-1:0]      rs2_addr,
  output logic                        rs1_busy,
  output logic                        rs2_busy
);

  localparam int PTRW  = $clog2(NREQ);
  localparam int NREGS = 2 ** RFIDX_WIDTH;

  logic [PTRW-1:0]        rr_ptr;
  logic [NREQ-1:0]        gnt;
  logic [PTRW-1:0]        gnt_idx;
  logic                   gnt_valid;
  logic                   transfer;
  logic [RFIDX_WIDTH-1:0] sel_addr;
  logic [XLEN-1:0]        sel_data;
  logic [NREGS-1:0]       busy;
  logic                   iss_fire;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req       (wb_valid),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Grants are suppressed while reset is held so nothing is accepted then
  assign wb_ready = rst_n ? gnt : '0;
  assign transfer = rst_n & gnt_valid;
  assign sel_addr = wb_addr[int'(gnt_idx)*RFIDX_WIDTH +: RFIDX_WIDTH];
  assign sel_data = wb_data[int'(gnt_idx)*XLEN +: XLEN];

  // busy[0] is never set, so x0 always reads as free
  assign iss_ready = ~busy[iss_rd];
  assign iss_fire  = iss_valid & iss_ready & (iss_rd != '0);
  assign rs1_busy  = busy[rs1_addr];
  assign rs2_busy  = busy[rs2_addr];

  // Advance the round-robin pointer past whoever just transferred
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= PTRW'(rr_next(int'(gnt_idx), NREQ));
    end
  end

  // Write stage: accepted result is presented to the regfile next cycle;
  // x0 results are swallowed by keeping reg_write low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      reg_write <= transfer && (sel_addr != '0);
      if (transfer) begin
        write_addr <= sel_addr;
        write_data <= sel_data;
      end
    end
  end

  // Scoreboard: clear on commit, set on issue; the two never hit the same
  // index because a busy rd blocks issue
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      automatic logic [NREGS-1:0] nxt = busy;
      if (reg_write) nxt[write_addr] = 1'b0;
      if (iss_fire)  nxt[iss_rd]     = 1'b1;
      nxt[0] = 1'b0;
      busy <= nxt;
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) $onehot0(wb_ready));
  a_no_x0_write:   assert property (@(posedge clk) disable iff (!rst_n)
                                    !(reg_write && write_addr == '0));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, round-robin,
// scoreboard stalls, x0 handling and mid-operation reset.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XL   = 32;
  localparam int RW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   wb_valid;
  logic [NREQ-1:0]   wb_ready;
  logic [NREQ*RW-1:0] wb_addr;
  logic [NREQ*XL-1:0] wb_data;
  logic              reg_write;
  logic [RW-1:0]     write_addr;
  logic [XL-1:0]     write_data;
  logic              iss_valid;
  logic [RW-1:0]     iss_rd;
  logic              iss_ready;
  logic [RW-1:0]     rs1_addr;
  logic [RW-1:0]     rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;

  int vectors = 0;
  int miscompares = 0;

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XL), .RFIDX_WIDTH(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .reg_write  (reg_write),
    .write_addr (write_addr),
    .write_data (write_data),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one cycle; sample point is 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [RW-1:0] a, input logic [XL-1:0] d);
    wb_addr[i*RW +: RW] = a;
    wb_data[i*XL +: XL] = d;
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = '0; wb_addr = '0; wb_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;

    // 1. Reset held 3 cycles with every requester valid
    set_src(0, 5'd1, 32'h11); set_src(1, 5'd2, 32'h22); set_src(2, 5'd3, 32'h33);
    wb_valid = 3'b111;
    iss_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd9;
    repeat (3) step();
    check_vec("rst_ready", wb_ready, 3'b000);
    check_vec("rst_reg_write", reg_write, 1'b0);
    check_vec("rst_write_addr", write_addr, 5'd0);
    check_vec("rst_write_data", write_data, 32'd0);
    check_vec("rst_rs1_busy", rs1_busy, 1'b0);
    check_vec("rst_rs2_busy", rs2_busy, 1'b0);
    check_vec("rst_iss_ready", iss_ready, 1'b1);

    // 2. Single write from src0
    rst_n = 1'b1; wb_valid = 3'b001;
    set_src(0, 5'd5, 32'hDEADBEEF);
    #1 check_vec("single_ready", wb_ready, 3'b001);
    step(); wb_valid = '0;
    check_vec("single_reg_write", reg_write, 1'b1);
    check_vec("single_addr", write_addr, 5'd5);
    check_vec("single_data", write_data, 32'hDEADBEEF);
    step();
    check_vec("single_idle", reg_write, 1'b0);

    // ptr is 1 now; src2 to x0 brings it back to 0
    wb_valid = 3'b100; set_src(2, 5'd0, 32'h55);
    #1 check_vec("wrap_ready", wb_ready, 3'b100);
    step(); wb_valid = '0;
    check_vec("wrap_x0_no_write", reg_write, 1'b0);

    // 3. Round-robin with all sources valid: 0,1,2,0,1,2
    set_src(0, 5'd1, 32'hA0); set_src(1, 5'd2, 32'hB1); set_src(2, 5'd3, 32'hC2);
    wb_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      automatic int g = k % 3;
      #1 check_vec($sformatf("rr_ready_%0d", k), wb_ready, 3'b001 << g);
      step();
      check_vec($sformatf("rr_addr_%0d", k), write_addr, 5'(g + 1));
      check_vec($sformatf("rr_we_%0d", k), reg_write, 1'b1);
    end
    wb_valid = '0;
    step();

    // 4. Scoreboard on rd=7
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1 check_vec("sb_issue_ready", iss_ready, 1'b1);
    step(); iss_valid = 1'b0;
    rs1_addr = 5'd7; rs2_addr = 5'd8;
    #1 check_vec("sb_rs1_busy", rs1_busy, 1'b1);
    check_vec("sb_rs2_free", rs2_busy, 1'b0);
    check_vec("sb_waw_stall", iss_ready, 1'b0);
    wb_valid = 3'b001; set_src(0, 5'd7, 32'h77);
    #1 check_vec("sb_wb_ready", wb_ready, 3'b001);
    step(); wb_valid = '0;
    check_vec("sb_commit_we", reg_write, 1'b1);
    check_vec("sb_commit_addr", write_addr, 5'd7);
    check_vec("sb_busy_during_commit", rs1_busy, 1'b1);
    step();
    check_vec("sb_busy_cleared", rs1_busy, 1'b0);
    check_vec("sb_reissue_ready", iss_ready, 1'b1);

    // 5. x0 writeback from src1 (ptr is 1)
    wb_valid = 3'b010; set_src(1, 5'd0, 32'h1234);
    #1 check_vec("x0_ready", wb_ready, 3'b010);
    step(); wb_valid = '0;
    check_vec("x0_no_write", reg_write, 1'b0);
    iss_valid = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
    #1 check_vec("x0_iss_ready", iss_ready, 1'b1);
    step(); iss_valid = 1'b0;
    check_vec("x0_rs1_busy", rs1_busy, 1'b0);

    // Set 9, write 9 back while issuing 3 in the commit cycle (ptr is 2)
    iss_valid = 1'b1; iss_rd = 5'd9;
    step(); iss_valid = 1'b0;
    wb_valid = 3'b010; set_src(1, 5'd9, 32'h99);
    #1 check_vec("mix_ready", wb_ready, 3'b010);
    step(); wb_valid = '0;
    iss_valid = 1'b1; iss_rd = 5'd3;
    check_vec("mix_commit_addr", write_addr, 5'd9);
    step(); iss_valid = 1'b0;
    rs1_addr = 5'd9; rs2_addr = 5'd3;
    #1 check_vec("mix_clear9", rs1_busy, 1'b0);
    check_vec("mix_set3", rs2_busy, 1'b1);

    // 6. Mid-operation reset: busy 3 and 9, write to x12 in flight
    iss_valid = 1'b1; iss_rd = 5'd9;
    step(); iss_valid = 1'b0;
    wb_valid = 3'b001; set_src(0, 5'd12, 32'hC0C0);
    #1 check_vec("midrst_ready", wb_ready, 3'b001);
    step();
    check_vec("midrst_inflight", reg_write, 1'b1);
    check_vec("midrst_busy9", rs1_busy, 1'b1);
    rst_n = 1'b0; wb_valid = 3'b111;
    #1 check_vec("midrst_ready_gated", wb_ready, 3'b000);
    step();
    check_vec("midrst_we", reg_write, 1'b0);
    check_vec("midrst_waddr", write_addr, 5'd0);
    check_vec("midrst_busy9_clr", rs1_busy, 1'b0);
    check_vec("midrst_busy3_clr", rs2_busy, 1'b0);
    rst_n = 1'b1;
    #1 check_vec("midrst_ptr0", wb_ready, 3'b001);
    wb_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
